// File: rtl/down_count_timer.sv
// ---------------------------------------------------------------------------
// down_count_timer
//
// Loadable down-counter / timer. A programmed value is counted down toward
// zero; the step after reaching zero (the terminal step) raises a one-cycle
// terminal-count pulse. The timer then either stops (one-shot) or reloads
// the programmed value and repeats (periodic). For load_val = N the period
// in periodic mode is N+1 step events, because the count covers N..0.
//
// Parameters
//   DATA_SIZE  counter and load width in bits (default 4)
//   PRESCALE   enabled RUN cycles per count step, legal range 2..256
//              (default 4); only used when DOWN_COUNT_TIMER_PRESCALE_EN
//              is defined
//
// Optional feature macro
//   DOWN_COUNT_TIMER_PRESCALE_EN
//     defined     : a prescale counter divides the enabled RUN cycles, and a
//                   step event occurs once every PRESCALE enabled cycles
//     not defined : every RUN cycle with en=1 is a step event
//
// Ports
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   load         in   1          load strobe, sampled each rising edge;
//                                has priority over everything else
//   load_val     in   DATA_SIZE  start/reload value captured when load=1
//   en           in   1          count enable
//   auto_reload  in   1          1 = periodic, 0 = one-shot; sampled only at
//                                the terminal step
//   q_out        out  DATA_SIZE  current count (registered)
//   tc           out  1          terminal-count pulse (registered, 1 cycle)
//   busy         out  1          high while the FSM is in RUN (registered)
//
// Behaviour summary
//   - load with load_val != 0 enters RUN; load with load_val == 0 parks the
//     timer in IDLE with q_out = 0 and no tc.
//   - IDLE ignores en; only load leaves IDLE.
//   - q_out never wraps from 0 to all-ones: a step at zero is the terminal
//     step, not a decrement.
//   - A load on the same edge as a terminal step wins, so no tc is produced.
// ---------------------------------------------------------------------------
module down_count_timer #(
  parameter int DATA_SIZE = 4,
  parameter int PRESCALE  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_val,
  input  logic                 en,
  input  logic                 auto_reload,
  output logic [DATA_SIZE-1:0] q_out,
  output logic                 tc,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DATA_SIZE-1:0] ZERO = '0;
  localparam logic [DATA_SIZE-1:0] ONE  = DATA_SIZE'(1);

  state_t               state;
  logic [DATA_SIZE-1:0] reload_reg;
  logic                 step;

`ifdef DOWN_COUNT_TIMER_PRESCALE_EN
  // -------------------------------------------------------------------------
  // Prescaler: counts enabled RUN cycles and produces a step event on the
  // cycle it sits at PRESCALE-1, wrapping back to 0 on that same edge. It is
  // cleared by load so every loaded value gets a full first period, and it
  // freezes (keeps its phase) while en=0 or while the timer is IDLE.
  // -------------------------------------------------------------------------
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (load) begin
      ps_cnt <= '0;
    end else if ((state == RUN) && en) begin
      if (ps_cnt == PS_LAST) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + PS_ONE;
      end
    end
  end

  assign step = (state == RUN) && en && (ps_cnt == PS_LAST);
`else
  // Without the prescaler every enabled RUN cycle advances the count.
  assign step = (state == RUN) && en;
`endif

  // -------------------------------------------------------------------------
  // Timer FSM with registered outputs. busy mirrors the state but is kept as
  // its own flop so it changes on exactly the same edge as state and tc.
  // -------------------------------------------------------------------------
  // NOTE: every state flop here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      q_out      <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // tc is a single-cycle pulse: cleared unless a terminal step sets it.
      tc <= 1'b0;

      if (load) begin
        reload_reg <= load_val;
        q_out      <= load_val;
        if (load_val != ZERO) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else if (step) begin
        if (q_out != ZERO) begin
          q_out <= q_out - ONE;
        end else begin
          // Terminal step: q_out is already 0, so no decrement/wrap.
          tc <= 1'b1;
          if (auto_reload) begin
            // reload_reg is non-zero here: RUN is only entered with a
            // non-zero load value.
            q_out <= reload_reg;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_down_count_timer.sv
// ---------------------------------------------------------------------------
// tb_down_count_timer
//
// Directed testbench for down_count_timer with DATA_SIZE=4, PRESCALE=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. they reflect the edge just taken. Expected values are written
// out by hand from the timer's behaviour.
// The prescaled sequence is exercised when DOWN_COUNT_TIMER_PRESCALE_EN is
// defined for both files; otherwise the unprescaled sequences run.
// ---------------------------------------------------------------------------
module tb_down_count_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] q_out;
  logic       tc;
  logic       busy;

  int total = 0;
  int bad   = 0;

  down_count_timer #(
    .DATA_SIZE (4),
    .PRESCALE  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q_out       (q_out),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all three outputs at once.
  task automatic expect_out(input string tag, input logic [3:0] q,
                            input logic t, input logic b);
    check({tag, ".q"},    {28'd0, q_out}, {28'd0, q});
    check({tag, ".tc"},   {31'd0, tc},    {31'd0, t});
    check({tag, ".busy"}, {31'd0, busy},  {31'd0, b});
  endtask

  // Pulse load for one edge with the given value.
  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    load        = 1'b0;
    load_val    = 4'd0;
    en          = 1'b0;
    auto_reload = 1'b0;

    // Reset is asserted before any clock edge: outputs must already be 0.
    #2;
    expect_out("reset_async", 4'd0, 1'b0, 1'b0);
    #6;
    reset = 1'b0;
    tick();

    // IDLE ignores en.
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("idle_en", 4'd0, 1'b0, 1'b0);
    end

`ifdef DOWN_COUNT_TIMER_PRESCALE_EN
    // Prescale 4, load 2: q_out changes every 4 edges, tc 12 edges after load.
    auto_reload = 1'b0;
    do_load(4'd2);
    expect_out("ps_load", 4'd2, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i < 4)       expect_out("ps_run", 4'd2, 1'b0, 1'b1);
      else if (i < 8)  expect_out("ps_run", 4'd1, 1'b0, 1'b1);
      else if (i < 12) expect_out("ps_run", 4'd0, 1'b0, 1'b1);
      else             expect_out("ps_tc",  4'd0, 1'b1, 1'b0);
    end

    // en=0 mid-period freezes the prescale phase.
    do_load(4'd2);
    tick(); tick();                       // phase 2
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("ps_freeze", 4'd2, 1'b0, 1'b1);
    end
    en = 1'b1;
    tick();                               // phase 3
    expect_out("ps_resume_a", 4'd2, 1'b0, 1'b1);
    tick();                               // step
    expect_out("ps_resume_b", 4'd1, 1'b0, 1'b1);
`else
    // One-shot, load 5: 5,4,3,2,1,0 then tc with busy falling.
    auto_reload = 1'b0;
    do_load(4'd5);
    expect_out("os_load", 4'd5, 1'b0, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      tick();
      expect_out("os_count", 4'(i), 1'b0, 1'b1);
    end
    tick();
    expect_out("os_tc", 4'd0, 1'b1, 1'b0);
    tick();
    expect_out("os_hold", 4'd0, 1'b0, 1'b0);

    // Periodic, load 3: 3,2,1,0,3... with tc on every reload.
    auto_reload = 1'b1;
    do_load(4'd3);
    expect_out("per_load", 4'd3, 1'b0, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      tick();
      expect_out("per_run", 4'(3 - (j % 4)), (j % 4) == 0, 1'b1);
    end

    // Enable gating, load 15.
    begin
      logic [6:0] en_pat;
      logic [3:0] q_exp [7];
      en_pat = 7'b1001101;   // applied LSB first: 1,0,1,1,0,0,1
      q_exp  = '{4'd14, 4'd14, 4'd13, 4'd12, 4'd12, 4'd12, 4'd11};
      do_load(4'd15);
      expect_out("gate_load", 4'd15, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
        en = en_pat[i];
        tick();
        expect_out("gate", q_exp[i], 1'b0, 1'b1);
      end
      en = 1'b1;
    end

    // Load collides with a terminal step: load wins, no tc.
    do_load(4'd1);
    tick();
    expect_out("coll_pre", 4'd0, 1'b0, 1'b1);
    do_load(4'd7);
    expect_out("coll_load", 4'd7, 1'b0, 1'b1);

    // Load of 0 parks the timer in IDLE without tc.
    do_load(4'd0);
    expect_out("load_zero", 4'd0, 1'b0, 1'b0);
    tick();
    expect_out("zero_idle", 4'd0, 1'b0, 1'b0);

    // auto_reload change mid-run applies at the next terminal step.
    auto_reload = 1'b1;
    do_load(4'd2);
    auto_reload = 1'b0;
    tick();
    expect_out("ar_a", 4'd1, 1'b0, 1'b1);
    tick();
    expect_out("ar_b", 4'd0, 1'b0, 1'b1);
    tick();
    expect_out("ar_tc", 4'd0, 1'b1, 1'b0);

    // Async reset mid-count with q_out=9.
    do_load(4'd12);
    tick(); tick(); tick();
    expect_out("rst_pre", 4'd9, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("rst_mid", 4'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst_held", 4'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    expect_out("rst_idle", 4'd0, 1'b0, 1'b0);
    do_load(4'd1);
    expect_out("rst_reload", 4'd1, 1'b0, 1'b1);
    tick();
    expect_out("rst_count", 4'd0, 1'b0, 1'b1);
    tick();
    expect_out("rst_tc", 4'd0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/down_count_timer.md
# down_count_timer

Loadable down-counter/timer counting from a programmed value toward zero, the counterpart of the free-running 4-bit up counter in the same lab design set. It raises a one-cycle terminal-count pulse on expiry and then either stops (one-shot) or reloads and repeats (periodic). It sits beside the up counter as the timebase/delay generator for downstream control logic.

## Interface
- DATA_SIZE, 4, counter and load width in bits
- PRESCALE, 4, enabled cycles per count step; only used when DOWN_COUNT_TIMER_PRESCALE_EN is defined; legal range 2..256
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  load strobe; sampled each rising edge
- load_val  input  DATA_SIZE  start/reload value captured when load=1
- en  input  1  count enable
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at terminal step
- q_out  output  DATA_SIZE  current count (registered)
- tc  output  1  terminal-count pulse (registered, one cycle)
- busy  output  1  1 while FSM is in RUN (registered)

One clock; reset is asynchronous and active-high (ports clk and reset).

## Operation
- Reset (async assert): q_out=0, internal reload register=0, tc=0, busy=0, FSM=IDLE, prescale counter=0.
- FSM states: IDLE (hold q_out, busy=0), RUN (counting, busy=1).
- Load (highest priority, any state): reload register<=load_val, q_out<=load_val, prescale counter<=0, tc<=0.
  - load_val!=0 -> RUN. load_val==0 -> IDLE, no tc.
- RUN, step event, q_out!=0: q_out<=q_out-1, tc<=0.
- RUN, step event, q_out==0 (terminal step): tc<=1 for exactly one cycle.
  - auto_reload=1: q_out<=reload register, stay RUN.
  - auto_reload=0: q_out stays 0, -> IDLE.
- Step event = en=1 (without macro) or en=1 and prescale counter==PRESCALE-1 (with macro).
- en=0: q_out, state, prescale counter hold; tc=0.
- IDLE ignores en; only load leaves IDLE.
- Arithmetic: unsigned modulo 2^DATA_SIZE; q_out never decrements below 0 (no 0->all-ones wrap).
- Period in periodic mode = N+1 step events for load_val=N (counts N..0 inclusive).

## Timing
- Load at edge k -> q_out=load_val, busy=1 visible after edge k.
- With en held high, no macro, load_val=N: q_out=0 after edge k+N; tc=1 after edge k+N+1 for one cycle; one-shot busy=0 after same edge.
- tc coincides with the reloaded q_out (periodic) or with busy falling (one-shot).
- load on the same edge as a terminal step: load wins, no tc, q_out=load_val.
- auto_reload change mid-run takes effect at the next terminal step.
- Reset mid-count: all outputs 0 immediately, independent of clk; count resumes only after a new load.

## Configuration
- DOWN_COUNT_TIMER_PRESCALE_EN defined: internal counter of width clog2(PRESCALE) increments on each RUN cycle with en=1, wraps at PRESCALE-1, and produces the step event on wrap; cleared by reset and load; holds when en=0 or in IDLE.
- Not defined: no prescale logic, PRESCALE ignored, every RUN cycle with en=1 is a step event.

## Test plan
- Reset then idle: reset=1 mid-cycle -> q_out=0, tc=0, busy=0 immediately; en=1 without load -> q_out stays 0.
- One-shot: load_val=5, auto_reload=0, en=1 -> q_out 5,4,3,2,1,0; tc=1 one cycle 6 edges after load; busy falls with tc; q_out holds 0.
- Periodic: load_val=3, auto_reload=1, en=1 for 12 cycles -> q_out 3,2,1,0,3,2,1,0...; tc every 4th cycle, single-cycle.
- Enable gating and collision: load_val=15, toggle en 1/0 -> q_out steps only on en=1; load_val=7 on terminal-step edge -> q_out=7, no tc; load_val=0 -> IDLE, busy=0, no tc.
- Prescale (macro on, PRESCALE=4): load_val=2, en=1 -> q_out changes every 4 cycles; tc 12 cycles after load; en=0 mid-period freezes prescale phase.
- Async reset during RUN with q_out=9 -> q_out=0, busy=0 immediately; subsequent load_val=1 restarts normally.
